// File: rtl/led_pkg.sv
// Shared codes for the LED pattern sequencer: pattern modes and controller states.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int STEP_CNT_W = 8;

endpackage

// File: rtl/tick_edge_detect.sv
// Brings an asynchronous level into the clk domain and emits a one-cycle pulse on
// each rising edge. Also used for debouncing-free button inputs elsewhere.
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= async_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    // Pulse is driven purely from flops, so the consumer sees it on the third clk edge after the input rises.
    assign rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps the LED bank through CHASE/BOUNCE/FILL/BLINK patterns once per rising edge of
// the divider's slow square wave, with start/stop control and an optional run length.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int P_LED_WIDTH = 16,
    parameter int P_RUN_STEPS = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_slow_clk,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [1:0]             i_mode,
    output logic [P_LED_WIDTH-1:0] o_led,
    output logic                   o_busy,
    output logic [STEP_CNT_W-1:0]  o_step_cnt,
    output logic                   o_done
);

    localparam logic [P_LED_WIDTH-1:0] LED_ONE     = {{(P_LED_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STEP_CNT_W-1:0]  RUN_LIMIT   = STEP_CNT_W'(P_RUN_STEPS);
    localparam bit                     RUN_LIMITED = (P_RUN_STEPS != 0);

    state_e                  state, state_n;
    mode_e                   mode, mode_n;
    mode_e                   mode_in;
    logic                    dir_up, dir_up_n;
    logic [P_LED_WIDTH-1:0]  led, led_n;
    logic [STEP_CNT_W-1:0]   cnt, cnt_n;
    logic                    busy, busy_n;
    logic                    done, done_n;
    logic                    step;

    function automatic logic [P_LED_WIDTH-1:0] init_pattern(input mode_e m);
        return (m == MODE_BLINK) ? {P_LED_WIDTH{1'b1}} : LED_ONE;
    endfunction

    tick_edge_detect u_tick (
        .clk      (i_clk),
        .rst      (i_rst),
        .async_in (i_slow_clk),
        .rise     (step)
    );

    assign mode_in = mode_e'(i_mode);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            mode   <= MODE_CHASE;
            dir_up <= 1'b1;
            led    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            mode   <= mode_n;
            dir_up <= dir_up_n;
            led    <= led_n;
            cnt    <= cnt_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_n  = state;
        mode_n   = mode;
        dir_up_n = dir_up;
        led_n    = led;
        cnt_n    = cnt;
        busy_n   = busy;
        done_n   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                led_n  = '0;
                busy_n = 1'b0;
                if (i_start && !i_stop) begin
                    state_n  = ST_RUN;
                    mode_n   = mode_in;
                    cnt_n    = '0;
                    led_n    = init_pattern(mode_in);
                    dir_up_n = 1'b1;
                    busy_n   = 1'b1;
                end
            end

            ST_RUN: begin
                // The final pattern stays on the LEDs for the done cycle; IDLE clears it next edge.
                if (i_stop) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (step) begin
                    cnt_n = cnt + 8'd1;
                    if (mode_in != mode) begin
                        mode_n   = mode_in;
                        led_n    = init_pattern(mode_in);
                        dir_up_n = 1'b1;
                    end else begin
                        unique case (mode)
                            MODE_CHASE:  led_n = {led[P_LED_WIDTH-2:0], led[P_LED_WIDTH-1]};
                            MODE_BOUNCE: begin
                                if (dir_up) begin
                                    led_n = led << 1;
                                    if (led_n[P_LED_WIDTH-1]) dir_up_n = 1'b0;
                                end else begin
                                    led_n = led >> 1;
                                    if (led_n[0]) dir_up_n = 1'b1;
                                end
                            end
                            MODE_FILL:   led_n = (&led) ? '0 : {led[P_LED_WIDTH-2:0], 1'b1};
                            MODE_BLINK:  led_n = ~led;
                            default:     led_n = LED_ONE;
                        endcase
                    end
                    if (RUN_LIMITED && (cnt_n == RUN_LIMIT)) begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    assign o_led      = led;
    assign o_busy     = busy;
    assign o_step_cnt = cnt;
    assign o_done     = done;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: table-driven vectors, directed corner sequences and a randomized
// run compared against a step-phase reference model of the LED patterns.
module tb_led_pattern_sequencer;
    import led_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        slow = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [1:0]  i_mode = 2'd0;

    logic [N-1:0] led0, led4;
    logic         busy0, busy4, done0, done4;
    logic [7:0]   cnt0, cnt4;

    int checks = 0;
    int errors = 0;

    led_pattern_sequencer #(.P_LED_WIDTH(N), .P_RUN_STEPS(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_slow_clk(slow), .i_start(i_start), .i_stop(i_stop),
        .i_mode(i_mode), .o_led(led0), .o_busy(busy0), .o_step_cnt(cnt0), .o_done(done0)
    );

    led_pattern_sequencer #(.P_LED_WIDTH(N), .P_RUN_STEPS(4)) dut_lim (
        .i_clk(clk), .i_rst(rst), .i_slow_clk(slow), .i_start(i_start), .i_stop(i_stop),
        .i_mode(i_mode), .o_led(led4), .o_busy(busy4), .o_step_cnt(cnt4), .o_done(done4)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Snapshots taken inside each tick: 2, 3 and 4 clk edges after the slow rise.
    logic [N-1:0] led_pre, led_at3, led_at4, led4_at3, led4_at4;
    logic         done_at3, done_at4, busy_at4, done4_at3, done4_at4, busy4_at4;

    task automatic tick(input bit stop_with_step);
        @(negedge clk); slow = 1'b1;
        @(negedge clk);
        @(negedge clk); led_pre = led0;
        if (stop_with_step) i_stop = 1'b1;
        @(negedge clk); i_stop = 1'b0;
        led_at3 = led0; done_at3 = done0; led4_at3 = led4; done4_at3 = done4;
        @(negedge clk);
        led_at4 = led0; done_at4 = done0; busy_at4 = busy0;
        led4_at4 = led4; done4_at4 = done4; busy4_at4 = busy4;
        repeat (6) @(negedge clk);
        slow = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    task automatic act_start();
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
    endtask

    task automatic act_stop(input bit with_start, output logic done_a, output logic [N-1:0] led_a,
                            output logic done_b, output logic [N-1:0] led_b);
        @(negedge clk); i_stop = 1'b1; i_start = with_start;
        @(negedge clk); i_stop = 1'b0; i_start = 1'b0;
        done_a = done0; led_a = led0;
        @(negedge clk);
        done_b = done0; led_b = led0;
    endtask

    // Reference model: a run is described by its mode and the number of steps since that
    // mode's init pattern was loaded; the LED value is a closed-form function of that phase.
    bit m_run;
    int m_mode, m_k, m_cnt;

    function automatic logic [N-1:0] model_led(input int m, input int k);
        int p;
        logic [31:0] v;
        case (m)
            0: v = 32'd1 << (k % N);
            1: begin p = k % (2*N-2); v = 32'd1 << ((p < N) ? p : (2*N-2) - p); end
            2: begin p = k % (N+1); v = (p == N) ? 32'd0 : ((32'd1 << (p+1)) - 32'd1); end
            default: v = ((k % 2) == 0) ? 32'hFFFF : 32'h0;
        endcase
        return v[N-1:0];
    endfunction

    function automatic logic [N-1:0] model_expect();
        return m_run ? model_led(m_mode, m_k) : '0;
    endfunction

    task automatic m_start();
        if (!m_run) begin m_run = 1; m_mode = int'(i_mode); m_k = 0; m_cnt = 0; end
    endtask

    task automatic m_step();
        if (m_run) begin
            m_cnt = (m_cnt + 1) % 256;
            if (int'(i_mode) != m_mode) begin m_mode = int'(i_mode); m_k = 0; end
            else m_k++;
        end
    endtask

    task automatic check_model(input string name);
        check({name, " led"}, 32'(led0), 32'(model_expect()));
        check({name, " busy"}, 32'(busy0), 32'(m_run));
        if (m_run) check({name, " cnt"}, 32'(cnt0), 32'(m_cnt));
    endtask

    task automatic do_reset();
        slow = 1'b0; i_start = 1'b0; i_stop = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_run = 0; m_mode = 0; m_k = 0; m_cnt = 0;
    endtask

    typedef enum {A_START, A_TICK, A_STOP, A_BOTH} act_e;
    typedef struct {
        act_e         act;
        mode_e        mode;
        logic [N-1:0] led;
        logic         busy;
        logic [7:0]   cnt;
        logic         done;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic         da, db;
        logic [N-1:0] la, lb;
        logic [N-1:0] prev_led;
        int           double_end;
        bit           was_run;
        logic [N-1:0] pre_stop;

        vecs[0]  = '{A_START, MODE_CHASE,  16'h0001, 1'b1, 8'd0, 1'b0};
        vecs[1]  = '{A_TICK,  MODE_CHASE,  16'h0002, 1'b1, 8'd1, 1'b0};
        vecs[2]  = '{A_TICK,  MODE_CHASE,  16'h0004, 1'b1, 8'd2, 1'b0};
        vecs[3]  = '{A_TICK,  MODE_CHASE,  16'h0008, 1'b1, 8'd3, 1'b0};
        vecs[4]  = '{A_TICK,  MODE_BLINK,  16'hFFFF, 1'b1, 8'd4, 1'b0};
        vecs[5]  = '{A_TICK,  MODE_BLINK,  16'h0000, 1'b1, 8'd5, 1'b0};
        vecs[6]  = '{A_START, MODE_BLINK,  16'h0000, 1'b1, 8'd5, 1'b0};
        vecs[7]  = '{A_TICK,  MODE_BOUNCE, 16'h0001, 1'b1, 8'd6, 1'b0};
        vecs[8]  = '{A_TICK,  MODE_BOUNCE, 16'h0002, 1'b1, 8'd7, 1'b0};
        vecs[9]  = '{A_BOTH,  MODE_BOUNCE, 16'h0000, 1'b0, 8'd0, 1'b1};
        vecs[10] = '{A_BOTH,  MODE_CHASE,  16'h0000, 1'b0, 8'd0, 1'b0};
        vecs[11] = '{A_START, MODE_FILL,   16'h0001, 1'b1, 8'd0, 1'b0};
        vecs[12] = '{A_TICK,  MODE_FILL,   16'h0003, 1'b1, 8'd1, 1'b0};
        vecs[13] = '{A_STOP,  MODE_FILL,   16'h0000, 1'b0, 8'd0, 1'b1};

        // Reset state
        do_reset();
        check("reset led", 32'(led0), 32'h0);
        check("reset busy", 32'(busy0), 32'h0);
        check("reset cnt", 32'(cnt0), 32'h0);
        check("reset done", 32'(done0), 32'h0);

        // Reset mid-run at CHASE 0x0010 clears outputs without waiting for a clock edge
        i_mode = MODE_CHASE;
        act_start();
        repeat (4) tick(1'b0);
        check("midrun led before reset", 32'(led0), 32'h0010);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        check("async reset led", 32'(led0), 32'h0);
        check("async reset busy", 32'(busy0), 32'h0);
        check("async reset cnt", 32'(cnt0), 32'h0);
        check("async reset done", 32'(done0), 32'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("after reset done", 32'(done0), 32'h0);

        // CHASE over a full rotation, with step latency checked on every tick
        do_reset();
        i_mode = MODE_CHASE;
        act_start();
        check("chase init", 32'(led0), 32'h0001);
        for (int i = 1; i <= 17; i++) begin
            tick(1'b0);
            check($sformatf("chase latency hold %0d", i), 32'(led_pre), 32'(16'h1 << ((i-1) % N)));
            check($sformatf("chase step %0d", i), 32'(led_at3), 32'(16'h1 << (i % N)));
        end
        check("chase cnt 17", 32'(cnt0), 32'd17);

        // BOUNCE: ends reached at steps 15 and 30, never held for two steps
        do_reset();
        i_mode = MODE_BOUNCE;
        act_start();
        m_start();
        double_end = 0;
        prev_led = led0;
        for (int i = 1; i <= 30; i++) begin
            tick(1'b0);
            m_step();
            check($sformatf("bounce step %0d", i), 32'(led_at3), 32'(model_expect()));
            if (led_at3 == prev_led) double_end++;
            prev_led = led_at3;
        end
        check("bounce no repeated value", 32'(double_end), 32'd0);

        // FILL: full, empty, then restart from a single LED
        do_reset();
        i_mode = MODE_FILL;
        act_start();
        m_start();
        for (int i = 1; i <= 18; i++) begin
            tick(1'b0);
            m_step();
            check($sformatf("fill step %0d", i), 32'(led_at3), 32'(model_expect()));
        end

        // Bounded run of 4 BLINK steps on the limited instance
        do_reset();
        i_mode = MODE_BLINK;
        act_start();
        check("limit init", 32'(led4), 32'hFFFF);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0);
            check($sformatf("limit step %0d", i), 32'(led4_at3), (i % 2 == 1) ? 32'h0 : 32'hFFFF);
            check($sformatf("limit done %0d", i), 32'(done4_at3), 32'(i == 4));
        end
        check("limit done one cycle", 32'(done4_at4), 32'h0);
        check("limit busy after", 32'(busy4_at4), 32'h0);
        check("limit led after", 32'(led4_at4), 32'h0);
        tick(1'b0);
        check("limit stays idle", 32'(led4_at3), 32'h0);

        // Table-driven sequence: mode change, ignored start, start+stop in RUN and in IDLE
        do_reset();
        for (int i = 0; i < $size(vecs); i++) begin
            i_mode = vecs[i].mode;
            case (vecs[i].act)
                A_START: act_start();
                A_TICK:  tick(1'b0);
                default: begin
                    act_stop(vecs[i].act == A_BOTH, da, la, db, lb);
                    check($sformatf("vec %0d done", i), 32'(da), 32'(vecs[i].done));
                    check($sformatf("vec %0d done cleared", i), 32'(db), 32'h0);
                end
            endcase
            check($sformatf("vec %0d led", i), 32'(led0), 32'(vecs[i].led));
            check($sformatf("vec %0d busy", i), 32'(busy0), 32'(vecs[i].busy));
            if (vecs[i].busy) check($sformatf("vec %0d cnt", i), 32'(cnt0), 32'(vecs[i].cnt));
        end

        // Stop coincident with a step: pattern frozen during done, then cleared
        do_reset();
        i_mode = MODE_CHASE;
        act_start();
        repeat (3) tick(1'b0);
        check("stop+step pre", 32'(led0), 32'h0008);
        tick(1'b1);
        check("stop+step led held", 32'(led_at3), 32'h0008);
        check("stop+step done", 32'(done_at3), 32'h1);
        check("stop+step done width", 32'(done_at4), 32'h0);
        check("stop+step led cleared", 32'(led_at4), 32'h0);
        check("stop+step busy", 32'(busy_at4), 32'h0);

        // Randomized control against the reference model
        do_reset();
        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r < 7) begin
                if ($urandom_range(0, 3) == 0) i_mode = 2'($urandom_range(0, 3));
                tick(1'b0);
                m_step();
                check_model($sformatf("rand %0d tick", it));
            end else if (r < 9) begin
                i_mode = 2'($urandom_range(0, 3));
                act_start();
                m_start();
                check_model($sformatf("rand %0d start", it));
            end else if (r < 11) begin
                was_run = m_run;
                pre_stop = model_expect();
                act_stop(r == 10, da, la, db, lb);
                check($sformatf("rand %0d stop done", it), 32'(da), 32'(was_run));
                check($sformatf("rand %0d stop held", it), 32'(la), 32'(pre_stop));
                m_run = 0;
                check_model($sformatf("rand %0d stop", it));
            end else begin
                was_run = m_run;
                pre_stop = model_expect();
                tick(1'b1);
                check($sformatf("rand %0d stepstop done", it), 32'(done_at3), 32'(was_run));
                check($sformatf("rand %0d stepstop held", it), 32'(led_at3), 32'(pre_stop));
                m_run = 0;
                check_model($sformatf("rand %0d stepstop", it));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
